fracnet_t_sdiv_25s_16s_9s_seq: RTL

Sequential signed divider, the inverse of the 9s×16s→25s pipelined multiplier: it takes a 25-bit signed product-domain value and a 16-bit signed scale and recovers a 9-bit signed quotient plus a 16-bit signed remainder. It sits in the FracNet requantization path, where accumulated products are rescaled back to activation width. It uses a start/done handshake with a global `ce` stall and performs one quotient bit per enabled cycle.

---
 rtl/fracnet_t_sdiv_25s_16s_9s_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fracnet_t_sdiv_25s_16s_9s_seq.sv
// Sequential signed divider 25s / 16s -> 9s quotient + 16s remainder.
// Optional macro FRACNET_DIV_SAT_EN: clamp an overflowing quotient.
module fracnet_t_sdiv_25s_16s_9s_seq #(
  parameter int ID         = 32'd1,
  parameter int din0_WIDTH = 32'd25,
  parameter int din1_WIDTH = 32'd16,
  parameter int dout_WIDTH = 32'd9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] dout_rem,
  output logic                  ovf,
  output logic                  dz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [24:0] dvd_q;
  logic [15:0] dvs_q;
  logic [15:0] pr_q;
  logic        sgnq_q;
  logic        sgnr_q;
  logic        dz_q;

  logic [24:0] mag0_d;
  logic [15:0] mag1_d;
  logic [16:0] pr_sh_d;
  logic        ge_d;
  logic [16:0] pr_nx_d;
  logic [25:0] sq_d;
  logic        ovf_d;
  logic [15:0] rem_d;
  logic [8:0]  dout_d;
  logic        unused_ok;

  assign unused_ok = ^{ID, pr_nx_d[16]};

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    mag0_d  = din0[24] ? (~din0 + 25'd1) : din0;
    mag1_d  = din1[15] ? (~din1 + 16'd1) : din1;
    pr_sh_d = {pr_q, dvd_q[24]};
    ge_d    = pr_sh_d >= {1'b0, dvs_q};
    pr_nx_d = ge_d ? (pr_sh_d - {1'b0, dvs_q}) : pr_sh_d;
  end

  // Sign fix-up, overflow detection and quotient reporting.
  always_comb begin
    sq_d  = sgnq_q ? (-{1'b0, dvd_q}) : {1'b0, dvd_q};
    ovf_d = ~((sq_d[25:8] == '0) || (sq_d[25:8] == '1));
    rem_d = sgnr_q ? (-pr_q) : pr_q;
    if (dz_q) begin
      dout_d = sgnr_q ? 9'h100 : 9'h0FF;
    end else if (ovf_d) begin
`ifdef FRACNET_DIV_SAT_EN
      dout_d = sq_d[25] ? 9'h100 : 9'h0FF;
`else
      dout_d = sq_d[8:0];
`endif
    end else begin
      dout_d = sq_d[8:0];
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      pr_q     <= '0;
      sgnq_q   <= 1'b0;
      sgnr_q   <= 1'b0;
      dz_q     <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      dout     <= '0;
      dout_rem <= '0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sgnq_q  <= din0[24] ^ din1[15];
            sgnr_q  <= din0[24];
            dvd_q   <= mag0_d;
            dvs_q   <= mag1_d;
            dz_q    <= (din1 == '0);
            pr_q    <= '0;
            cnt_q   <= 5'd24;
            ready   <= 1'b0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          pr_q  <= pr_nx_d[15:0];
          dvd_q <= {dvd_q[23:0], ge_d};
          if (cnt_q == 5'd0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_FIX: begin
          dout     <= dout_d;
          dout_rem <= dz_q ? 16'd0 : rem_d;
          ovf      <= dz_q | ovf_d;
          dz       <= dz_q;
          done     <= 1'b1;
          ready    <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
